// File: rtl/wac_acq_pkg.sv
// Shared definitions for the serial-ADC acquisition engine: FSM encoding and
// a parameter sanity check used at elaboration.
package wac_acq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3,
        QUIET = 3'd4,
        DONE  = 3'd5
    } acqState_t;

    function automatic bit paramsOk(input int nch, input int dataW, input int frameBits,
                                    input int clkDiv, input int quietCyc, input int addrW);
        return (nch >= 1) && (nch <= 8) && (dataW >= 1) && (frameBits >= dataW) &&
               (clkDiv >= 1) && (quietCyc >= 1) && (addrW >= 1);
    endfunction

endpackage

// File: rtl/wac_sclk_gen.sv
// SCLK divider: CLK_DIV clk cycles per half period, low half first, and a
// period counter. Held idle-high (counters cleared) whenever shiftEn is low.
module wac_sclk_gen #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int PER_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             shiftEn,
    output logic             sclkAdc,
    output logic             riseStb,
    output logic             fallStb,
    output logic [PER_W-1:0] periodCnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] divCnt;
    logic             phase;
    logic             halfEnd;
    logic             lastPeriod;

    assign halfEnd    = (divCnt == DIV_W'(CLK_DIV - 1));
    assign lastPeriod = (periodCnt == PER_W'(FRAME_BITS - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            divCnt    <= '0;
            phase     <= 1'b0;
            periodCnt <= '0;
        end else if (!shiftEn) begin
            divCnt    <= '0;
            phase     <= 1'b0;
            periodCnt <= '0;
        end else if (halfEnd) begin
            divCnt <= '0;
            if (phase) begin
                periodCnt <= periodCnt + 1'b1;
                // Stay high after the final period so SCLK never dips as CS rises
                if (!lastPeriod)
                    phase <= 1'b0;
            end else begin
                phase <= 1'b1;
            end
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign sclkAdc = ~shiftEn | phase;
    assign riseStb = shiftEn & ~phase & halfEnd;
    assign fallStb = shiftEn & phase & halfEnd;

endmodule

// File: rtl/wac_adc_acq.sv
// N-channel serial-ADC acquisition: shared CS/SCLK, parallel deserialisers,
// channel-interleaved buffer writes. Optional macro WAC_ACQ_TESTPAT_EN adds a
// modeTest input that substitutes a counting pattern for the SDO data.
module wac_adc_acq
    import wac_acq_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4,
    parameter int QUIET_CYC  = 8,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic              stop,
    input  logic              modeCont,
    input  logic [ADDR_W-1:0] nSamples,
    input  logic [NCH-1:0]    sdoAdc,
`ifdef WAC_ACQ_TESTPAT_EN
    input  logic              modeTest,
`endif
    output logic              csAdc,
    output logic              sclkAdc,
    output logic              bufWe,
    output logic [ADDR_W-1:0] bufAddr,
    output logic [DATA_W-1:0] bufData,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sampleCnt,
    output logic              wrapFlag
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MAXC  = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int PER_W = $clog2(FRAME_BITS + 1);

    if (!paramsOk(NCH, DATA_W, FRAME_BITS, CLK_DIV, QUIET_CYC, ADDR_W)) begin : gBadParams
        $error("wac_adc_acq: parameter out of range");
    end

    acqState_t                     state, stateNext;
    logic [CNT_W-1:0]              cnt;
    logic [CH_W-1:0]               chIdx;
    logic                          lastCh;
    logic                          modeLat;
    logic [ADDR_W-1:0]             nLat;
    logic                          stopPend;
    logic [NCH-1:0][DATA_W-1:0]    sr;
    logic [DATA_W-1:0]             wrData;
    logic                          riseStb, fallStb, frameEnd;
    logic [PER_W-1:0]              periodCnt;
`ifdef WAC_ACQ_TESTPAT_EN
    logic [DATA_W-1:0]             patCnt;
`endif

    wac_sclk_gen #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .PER_W      (PER_W)
    ) uSclk (
        .clk       (clk),
        .rstN      (rstN),
        .shiftEn   (state == SHIFT),
        .sclkAdc   (sclkAdc),
        .riseStb   (riseStb),
        .fallStb   (fallStb),
        .periodCnt (periodCnt)
    );

    assign frameEnd = fallStb && (periodCnt == PER_W'(FRAME_BITS - 1));
    assign lastCh   = (chIdx == CH_W'(NCH - 1));

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (start && !stop)
                       stateNext = (modeCont || nSamples != '0) ? SETUP : DONE;
            SETUP: if (stop)                          stateNext = DONE;
                   else if (cnt == CNT_W'(CLK_DIV - 1)) stateNext = SHIFT;
            SHIFT: if (stop)          stateNext = DONE;
                   else if (frameEnd) stateNext = WRITE;
            WRITE: if (lastCh)
                       stateNext = (stop || stopPend) ? DONE : QUIET;
            QUIET: if (stop)
                       stateNext = DONE;
                   else if (cnt == CNT_W'(QUIET_CYC - 1))
                       stateNext = (!modeLat && sampleCnt == nLat) ? DONE : SETUP;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            cnt       <= '0;
            chIdx     <= '0;
            modeLat   <= 1'b0;
            nLat      <= '0;
            stopPend  <= 1'b0;
            bufAddr   <= '0;
            sampleCnt <= '0;
            wrapFlag  <= 1'b0;
`ifdef WAC_ACQ_TESTPAT_EN
            patCnt    <= '0;
`endif
        end else begin
            state <= stateNext;
            cnt   <= (stateNext != state) ? '0 : cnt + 1'b1;
            if (state == IDLE && stateNext == SETUP) begin
                modeLat   <= modeCont;
                nLat      <= nSamples;
                stopPend  <= 1'b0;
                chIdx     <= '0;
                bufAddr   <= '0;
                sampleCnt <= '0;
                wrapFlag  <= 1'b0;
`ifdef WAC_ACQ_TESTPAT_EN
                patCnt    <= '0;
`endif
            end
            if (state == WRITE) begin
                bufAddr <= bufAddr + 1'b1;
                if (&bufAddr)
                    wrapFlag <= 1'b1;
                chIdx <= lastCh ? '0 : chIdx + 1'b1;
                if (lastCh)
                    sampleCnt <= sampleCnt + 1'b1;
                // A stop mid-group is deferred so the buffer only holds whole groups
                if (stop)
                    stopPend <= 1'b1;
`ifdef WAC_ACQ_TESTPAT_EN
                patCnt <= patCnt + 1'b1;
`endif
            end
        end
    end

    // Shift on the edge where SCLK rises; truncation keeps the last DATA_W bits
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            sr <= '0;
        else if (riseStb)
            for (int c = 0; c < NCH; c++)
                sr[c] <= DATA_W'({sr[c], sdoAdc[c]});
    end

    always_comb begin
        wrData = sr[chIdx];
`ifdef WAC_ACQ_TESTPAT_EN
        if (modeTest)
            wrData = patCnt;
`endif
    end

    assign csAdc   = !(state == SETUP || state == SHIFT);
    assign bufWe   = (state == WRITE);
    assign bufData = bufWe ? wrData : '0;
    assign busy    = (state == SETUP) || (state == SHIFT) || (state == WRITE) || (state == QUIET);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_wac_adc_acq.sv
// Directed bench for wac_adc_acq (NCH=2, DATA_W=12, FRAME_BITS=16, CLK_DIV=4,
// QUIET_CYC=8, ADDR_W=4) with behavioural ADC models on both SDO lines.
module tb_wac_adc_acq;

    logic        clk = 1'b0, rstN = 1'b0;
    logic        start = 1'b0, stop = 1'b0, modeCont = 1'b0;
    logic [3:0]  nSamples = '0;
    logic [1:0]  sdoAdc = '0;
`ifdef WAC_ACQ_TESTPAT_EN
    logic        modeTest = 1'b0;
`endif
    logic        csAdc, sclkAdc, bufWe, busy, done, wrapFlag;
    logic [3:0]  bufAddr, sampleCnt;
    logic [11:0] bufData;

    wac_adc_acq #(
        .NCH(2), .DATA_W(12), .FRAME_BITS(16), .CLK_DIV(4), .QUIET_CYC(8), .ADDR_W(4)
    ) dut (
        .clk(clk), .rstN(rstN), .start(start), .stop(stop), .modeCont(modeCont),
        .nSamples(nSamples), .sdoAdc(sdoAdc),
`ifdef WAC_ACQ_TESTPAT_EN
        .modeTest(modeTest),
`endif
        .csAdc(csAdc), .sclkAdc(sclkAdc), .bufWe(bufWe), .bufAddr(bufAddr),
        .bufData(bufData), .busy(busy), .done(done), .sampleCnt(sampleCnt),
        .wrapFlag(wrapFlag)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, wrCnt = 0, doneCnt = 0, csFallCnt = 0, riseCnt = 0, csLowCyc = 0;
    int tRise0 = 0, tRise1 = 0, t0 = 0;
    logic prevSclk = 1'b1, prevCs = 1'b1;
    logic [11:0] mem [16];

    // ADC model: frame word = {junk nibble, base + step*frameIdx}, MSB first, changed on SCLK fall
    int frameIdx = 0, bitIdx = 0;
    logic [11:0] base0 = '0, base1 = '0, step = '0;
    logic [15:0] w0, w1;

    function automatic logic [15:0] adcWord(input logic [3:0] junk, input logic [11:0] base,
                                            input logic [11:0] stp, input int k);
        logic [11:0] v;
        v = base + 12'(int'(stp) * k);
        return {junk, v};
    endfunction

    always @(negedge csAdc) begin
        frameIdx++;
        bitIdx = 0;
    end

    always @(negedge sclkAdc) begin
        if (csAdc === 1'b0 && bitIdx < 16) begin
            w0 = adcWord(4'hF, base0, step, frameIdx);
            w1 = adcWord(4'h6, base1, step, frameIdx);
            sdoAdc[0] = w0[15 - bitIdx];
            sdoAdc[1] = w1[15 - bitIdx];
            bitIdx++;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bufWe === 1'b1) begin
            mem[bufAddr] = bufData;
            wrCnt++;
        end
        if (done === 1'b1) doneCnt++;
        if (csAdc === 1'b0) csLowCyc++;
        if (prevCs === 1'b1 && csAdc === 1'b0) csFallCnt++;
        if (prevSclk === 1'b0 && sclkAdc === 1'b1 && csAdc === 1'b0) begin
            if (riseCnt == 0) tRise0 = cyc;
            if (riseCnt == 1) tRise1 = cyc;
            riseCnt++;
        end
        prevSclk = sclkAdc;
        prevCs   = csAdc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clr();
        wrCnt = 0; doneCnt = 0; csFallCnt = 0; riseCnt = 0; csLowCyc = 0;
        tRise0 = 0; tRise1 = 0; frameIdx = 0;
        for (int i = 0; i < 16; i++) mem[i] = 12'hEEE;
    endtask

    task automatic pulseStart(input logic mc, input logic [3:0] ns);
        modeCont = mc; nSamples = ns; start = 1'b1;
        waitCyc(1);
        start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1;
        waitCyc(1);
        stop = 1'b0;
    endtask

    task automatic waitWr(input int n, input int budget);
        int k = 0;
        while (wrCnt < n && k < budget) begin
            waitCyc(1);
            k++;
        end
        chk("waitWr.timeout", 32'(wrCnt >= n), 32'd1);
    endtask

    task automatic waitDone(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            waitCyc(1);
            k++;
        end
        chk("waitDone.timeout", 32'(done), 32'd1);
    endtask

    initial begin
        // Reset values
        waitCyc(3);
        chk("rst.csAdc", 32'(csAdc), 32'd1);
        chk("rst.sclkAdc", 32'(sclkAdc), 32'd1);
        chk("rst.bufWe", 32'(bufWe), 32'd0);
        chk("rst.bufAddr", 32'(bufAddr), 32'd0);
        chk("rst.bufData", 32'(bufData), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.sampleCnt", 32'(sampleCnt), 32'd0);
        chk("rst.wrapFlag", 32'(wrapFlag), 32'd0);
        rstN = 1'b1;
        waitCyc(2);

        // Single-shot, 3 conversions of ABC/123; period 4+128+2+8 = 142
        clr(); base0 = 12'hABC; base1 = 12'h123; step = 12'h000;
        pulseStart(1'b0, 4'd3);
        t0 = cyc;
        chk("ss.busy", 32'(busy), 32'd1);
        waitDone(600);
        chk("ss.doneTime", 32'(cyc - t0), 32'd426);
        chk("ss.firstRise", 32'(tRise0 - t0), 32'd8);
        chk("ss.sclkPeriod", 32'(tRise1 - tRise0), 32'd8);
        waitCyc(3);
        chk("ss.wrCnt", 32'(wrCnt), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("ss.mem%0d", i), 32'(mem[i]), (i % 2 == 0) ? 32'hABC : 32'h123);
        chk("ss.sampleCnt", 32'(sampleCnt), 32'd3);
        chk("ss.bufAddr", 32'(bufAddr), 32'd6);
        chk("ss.rises", 32'(riseCnt), 32'd48);
        chk("ss.csLow", 32'(csLowCyc), 32'd396);
        chk("ss.csFalls", 32'(csFallCnt), 32'd3);
        chk("ss.doneCnt", 32'(doneCnt), 32'd1);
        chk("ss.busyEnd", 32'(busy), 32'd0);
        chk("ss.wrapFlag", 32'(wrapFlag), 32'd0);

        // Continuous with 4-bit address: wrap after conversion 8, stop in QUIET of conversion 9
        clr(); base0 = 12'h100; base1 = 12'h200; step = 12'h001;
        pulseStart(1'b1, 4'd0);
        waitWr(14, 1200);
        waitCyc(2);
        chk("cont.noWrapYet", 32'(wrapFlag), 32'd0);
        waitWr(16, 400);
        waitCyc(2);
        chk("cont.wrapSet", 32'(wrapFlag), 32'd1);
        chk("cont.sampleCnt8", 32'(sampleCnt), 32'd8);
        waitWr(18, 400);
        waitCyc(2);
        pulseStop();
        chk("cont.doneAfterStop", 32'(done), 32'd1);
        waitCyc(3);
        chk("cont.wrCnt", 32'(wrCnt), 32'd18);
        chk("cont.mem0", 32'(mem[0]), 32'h109);
        chk("cont.mem1", 32'(mem[1]), 32'h209);
        chk("cont.mem2", 32'(mem[2]), 32'h102);
        chk("cont.mem15", 32'(mem[15]), 32'h208);
        chk("cont.sampleCnt", 32'(sampleCnt), 32'd9);
        chk("cont.bufAddr", 32'(bufAddr), 32'd2);
        chk("cont.wrapFlag", 32'(wrapFlag), 32'd1);
        chk("cont.doneCnt", 32'(doneCnt), 32'd1);
        chk("cont.busy", 32'(busy), 32'd0);

        // Stop during SHIFT of conversion 2
        clr(); base0 = 12'h050; base1 = 12'h0A0; step = 12'h010;
        pulseStart(1'b0, 4'd5);
        waitWr(2, 300);
        waitCyc(30);
        chk("stopShift.csLow", 32'(csAdc), 32'd0);
        pulseStop();
        chk("stopShift.csHigh", 32'(csAdc), 32'd1);
        chk("stopShift.sclk", 32'(sclkAdc), 32'd1);
        chk("stopShift.done", 32'(done), 32'd1);
        chk("stopShift.busy", 32'(busy), 32'd0);
        waitCyc(5);
        chk("stopShift.wrCnt", 32'(wrCnt), 32'd2);
        chk("stopShift.mem0", 32'(mem[0]), 32'h060);
        chk("stopShift.mem1", 32'(mem[1]), 32'h0B0);
        chk("stopShift.sampleCnt", 32'(sampleCnt), 32'd1);
        chk("stopShift.doneCnt", 32'(doneCnt), 32'd1);

        // Stop during the first write of a group: the group still completes
        clr();
        pulseStart(1'b1, 4'd0);
        waitWr(1, 300);
        pulseStop();
        waitCyc(3);
        chk("stopWrite.wrCnt", 32'(wrCnt), 32'd2);
        chk("stopWrite.sampleCnt", 32'(sampleCnt), 32'd1);
        chk("stopWrite.doneCnt", 32'(doneCnt), 32'd1);
        chk("stopWrite.busy", 32'(busy), 32'd0);

        // Zero-length single-shot
        clr();
        pulseStart(1'b0, 4'd0);
        chk("zero.done", 32'(done), 32'd1);
        chk("zero.busy", 32'(busy), 32'd0);
        waitCyc(20);
        chk("zero.csFalls", 32'(csFallCnt), 32'd0);
        chk("zero.doneCnt", 32'(doneCnt), 32'd1);

        // Start while busy is ignored
        clr();
        pulseStart(1'b0, 4'd1);
        waitCyc(50);
        pulseStart(1'b0, 4'd3);
        waitDone(400);
        waitCyc(5);
        chk("busyStart.wrCnt", 32'(wrCnt), 32'd2);
        chk("busyStart.sampleCnt", 32'(sampleCnt), 32'd1);
        chk("busyStart.csFalls", 32'(csFallCnt), 32'd1);
        chk("busyStart.doneCnt", 32'(doneCnt), 32'd1);

        // Start and stop together in IDLE: stop wins
        clr();
        modeCont = 1'b1; start = 1'b1; stop = 1'b1;
        waitCyc(1);
        start = 1'b0; stop = 1'b0;
        chk("startStop.busy", 32'(busy), 32'd0);
        waitCyc(10);
        chk("startStop.csFalls", 32'(csFallCnt), 32'd0);
        chk("startStop.doneCnt", 32'(doneCnt), 32'd0);

        // Reset asserted mid-SHIFT
        clr();
        pulseStart(1'b1, 4'd0);
        waitCyc(40);
        chk("rstMid.csLow", 32'(csAdc), 32'd0);
        rstN = 1'b0;
        #1;
        chk("rstMid.csAdc", 32'(csAdc), 32'd1);
        chk("rstMid.sclkAdc", 32'(sclkAdc), 32'd1);
        chk("rstMid.bufWe", 32'(bufWe), 32'd0);
        chk("rstMid.busy", 32'(busy), 32'd0);
        chk("rstMid.done", 32'(done), 32'd0);
        waitCyc(3);
        rstN = 1'b1;
        waitCyc(10);
        chk("rstMid.doneCnt", 32'(doneCnt), 32'd0);
        chk("rstMid.csFalls", 32'(csFallCnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
